// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output block with one shared period counter and duty shadow.
// Duty updates are taken only at the period boundary; enable/mode changes apply next cycle.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

  logic [7:0]  prescaler_q, prescaler_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;
  logic        tick;
  logic        boundary;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick        = (prescaler_q == DivMax);
    prescaler_d = tick ? 8'd0 : prescaler_q + 8'd1;
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // Last tick of the period: the shadow loads so the new duty starts exactly at pwm_cnt == 0.
    boundary    = tick && (pwm_cnt_q == 8'hFF);
    duty_sh_d   = boundary ? pwm_duty_cycle : duty_sh_q;
    pwm_sig     = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);
    // Enable dominates; a non-PWM enabled channel drives a static 1.
    out_d          = en_out & (~en_pwm | {16{pwm_sig}});
    period_start_d = boundary;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= 8'd0;
      pwm_cnt_q      <= 8'd0;
      duty_sh_q      <= 8'd0;
      out_q          <= 16'd0;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (CLK_DIV 13 and 1) checked every cycle against a
// cycle-count arithmetic model, plus directed duty/extreme/update/enable/reset scenarios.
module tb_pwm_peripheral;

  localparam int DIV_A = 13;
  localparam int DIV_B = 1;
  localparam int P_A   = 256 * DIV_A;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out_a, out_b;
  logic        ps_a, ps_b;

  int checks = 0;
  int errors = 0;
  int sc = 0;
  int hi_cnt, ps_cnt;

  pwm_peripheral #(.CLK_DIV(DIV_A)) u_dut_a (
    .clock(clock), .rst_n(rst_n),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .out(out_a), .period_start(ps_a)
  );

  pwm_peripheral #(.CLK_DIV(DIV_B)) u_dut_b (
    .clock(clock), .rst_n(rst_n),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .out(out_b), .period_start(ps_b)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, sc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      sc++;
    end
  endtask

  task automatic step_to(input int c);
    while (sc < c) step(1);
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // Accumulates out_a[idx] high cycles and period_start pulses over n consecutive cycles.
  task automatic run_count(input int n, input int idx);
    repeat (n) begin
      hi_cnt += int'(out_a[idx]);
      ps_cnt += int'(ps_a);
      step(1);
    end
  endtask

  // Reference model: everything is derived from t = clocks since reset release.
  // Period k (k >= 1) uses the duty input present on the last cycle of period k-1.
  initial begin : compare
    int          t;
    int          d, p, cnt;
    logic [7:0]  cur_duty [2];
    logic [7:0]  nxt_duty [2];
    logic        prev_sig [2];
    logic [15:0] prev_eo, prev_ep, exp_out, got_out;
    logic        exp_ps, got_ps;
    t = 0;
    prev_eo = '0;
    prev_ep = '0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        t = 0;
        for (int i = 0; i < 2; i++) begin
          cur_duty[i] = 8'd0;
          nxt_duty[i] = 8'd0;
          prev_sig[i] = 1'b0;
        end
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_b", 32'(out_b), 32'd0);
        chk("rst_ps_a", 32'(ps_a), 32'd0);
        chk("rst_ps_b", 32'(ps_b), 32'd0);
      end else begin
        for (int i = 0; i < 2; i++) begin
          d = (i == 0) ? DIV_A : DIV_B;
          p = 256 * d;
          exp_ps = (t > 0) && (t % p == 0);
          if (exp_ps) cur_duty[i] = nxt_duty[i];
          for (int b = 0; b < 16; b++) begin
            if (t == 0 || !prev_eo[b]) exp_out[b] = 1'b0;
            else if (prev_ep[b])       exp_out[b] = prev_sig[i];
            else                       exp_out[b] = 1'b1;
          end
          got_out = (i == 0) ? out_a : out_b;
          got_ps  = (i == 0) ? ps_a : ps_b;
          chk((i == 0) ? "model_out_a" : "model_out_b", 32'(got_out), 32'(exp_out));
          chk((i == 0) ? "model_ps_a" : "model_ps_b", 32'(got_ps), 32'(exp_ps));
          cnt = (t / d) % 256;
          prev_sig[i] = (cur_duty[i] == 8'hFF) || (cnt < int'(cur_duty[i]));
          if (t % p == p - 1) nxt_duty[i] = pwm_duty_cycle;
        end
        prev_eo = {en_reg_out_15_8, en_reg_out_7_0};
        prev_ep = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        t++;
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b1;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out", 32'(out_a), 32'd0);
    chk("reset_ps", 32'(ps_a), 32'd0);

    // Release; static enables with PWM mode off.
    rst_n = 1'b1;
    sc = 0;
    set_en(16'h0FA5, 16'h0000);
    pwm_duty_cycle = 8'h80;
    step(1);
    chk("static_first", 32'(out_a), 32'h0FA5);
    step_to(100);
    chk("static_hold", 32'(out_a), 32'h0FA5);

    // 50% duty on channel 0, measured over period 1.
    set_en(16'h0001, 16'h0001);
    step_to(P_A + 1);
    hi_cnt = 0; ps_cnt = 0;
    run_count(P_A, 0);
    chk("duty50_high", 32'(hi_cnt), 32'd1664);
    chk("duty50_ps", 32'(ps_cnt), 32'd1);

    // Extremes: 0x00 for periods 3..5, 0xFF for periods 7..9.
    pwm_duty_cycle = 8'h00;
    step_to(3 * P_A + 1);
    hi_cnt = 0; ps_cnt = 0;
    run_count(3 * P_A, 0);
    chk("duty00_high", 32'(hi_cnt), 32'd0);
    pwm_duty_cycle = 8'hFF;
    step_to(7 * P_A + 1);
    hi_cnt = 0; ps_cnt = 0;
    run_count(3 * P_A, 0);
    chk("dutyff_high", 32'(hi_cnt), 32'd9984);
    chk("dutyff_ps", 32'(ps_cnt), 32'd3);

    // Mid-period update 0x40 -> 0xC0 at pwm_cnt = 100 of period 11.
    pwm_duty_cycle = 8'h40;
    step_to(11 * P_A + 1);
    hi_cnt = 0; ps_cnt = 0;
    run_count(1300, 0);
    pwm_duty_cycle = 8'hC0;
    run_count(P_A - 1300, 0);
    chk("update_cur_high", 32'(hi_cnt), 32'd832);
    chk("update_cur_ps", 32'(ps_cnt), 32'd1);
    hi_cnt = 0; ps_cnt = 0;
    run_count(P_A, 0);
    chk("update_next_high", 32'(hi_cnt), 32'd2496);
    chk("update_next_ps", 32'(ps_cnt), 32'd1);

    // Enable dominance on channel 3, then enabling it follows pwm_sig next cycle.
    set_en(16'h0001, 16'h0009);
    step(2);
    chk("dominance", 32'(out_a[3]), 32'd0);
    set_en(16'h0009, 16'h0009);
    step(1);
    chk("enable_latency", 32'(out_a[3]), 32'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int k = 0; k < 3 * P_A; k++) begin
      if ($urandom_range(7) == 0) set_en(16'($urandom), 16'($urandom));
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(3))
          0:       pwm_duty_cycle = 8'h00;
          1:       pwm_duty_cycle = 8'hFF;
          default: pwm_duty_cycle = 8'($urandom);
        endcase
      end
      step(1);
    end

    // Reset mid-period at pwm_cnt = 77 with all outputs high.
    set_en(16'hFFFF, 16'h0000);
    step(2);
    while (((sc / DIV_A) % 256) != 77) step(1);
    chk("pre_reset_out", 32'(out_a), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", 32'(out_a), 32'd0);
    chk("async_reset_ps", 32'(ps_a), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    sc = 0;
    set_en(16'h0001, 16'h0001);
    pwm_duty_cycle = 8'h01;
    step_to(P_A);
    chk("after_reset_preload", 32'(out_a[0]), 32'd0);
    chk("after_reset_ps", 32'(ps_a), 32'd1);
    step(1);
    chk("after_reset_load", 32'(out_a[0]), 32'd1);
    step_to(2 * P_A + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter: CLK_DIV, default 13, prescaler divide ratio; legal range 1..255; 13 gives about 3.0 kHz PWM from a 10 MHz clock.
REQ-002 Port: clock  input  1  system clock, 10 MHz.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: en_reg_out_7_0  input  8  output-enable bits for out[7:0].
REQ-005 Port: en_reg_out_15_8  input  8  output-enable bits for out[15:8].
REQ-006 Port: en_reg_pwm_7_0  input  8  PWM-mode select bits for out[7:0].
REQ-007 Port: en_reg_pwm_15_8  input  8  PWM-mode select bits for out[15:8].
REQ-008 Port: pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%.
REQ-009 Port: out  output  16  registered drive outputs.
REQ-010 Port: period_start  output  1  one-cycle pulse, registered, on the first clock of each PWM period.
REQ-011 All inputs are synchronous to clock, driven by register outputs, and may change on any cycle.

Function
REQ-012 Prescaler: unsigned counter that counts 0..CLK_DIV-1 and wraps to 0. Tick is asserted combinationally when prescaler == CLK_DIV-1. With CLK_DIV=1, tick is asserted every cycle.
REQ-013 Period counter pwm_cnt: 8 bits; increments by 1 on tick; wraps 255 -> 0; holds when tick is low.
REQ-014 PWM period is exactly 256*CLK_DIV clock cycles (3328 cycles at default).
REQ-015 Duty shadow register duty_sh: loads pwm_duty_cycle on the cycle where tick is high and pwm_cnt == 255. It holds at all other times, so duty changes never take effect mid-period.
REQ-016 PWM level pwm_sig = 1 when duty_sh == 0xFF; otherwise 1 when pwm_cnt < duty_sh, else 0.
REQ-017 High time per period = duty_sh*CLK_DIV cycles for duty_sh < 255, and the full period for 255. 0x00 gives a constant 0 with no glitch.
REQ-018 Per bit i (en_out = {en_reg_out_15_8, en_reg_out_7_0}, en_pwm likewise), the next value of out[i] is:
  - 0 when en_out[i] = 0;
  - pwm_sig when en_out[i] = 1 and en_pwm[i] = 1;
  - 1 when en_out[i] = 1 and en_pwm[i] = 0.
REQ-019 Latency: out reflects enable, mode and pwm_sig changes exactly 1 clock after the input or counter change; out is registered and glitch-free.
REQ-020 en_pwm[i] = 1 with en_out[i] = 0 yields out[i] = 0, because enable dominates.
REQ-021 period_start is 1 on the cycle after pwm_cnt wraps from 255 to 0 (i.e. the first cycle of pwm_cnt == 0) and 0 otherwise.
REQ-022 Simultaneous events: a pwm_duty_cycle change on the same cycle as the boundary load is captured (the new value is loaded). Enable changes need no boundary and apply immediately per REQ-019.
REQ-023 All 16 channels share one pwm_cnt and one duty_sh; PWM edges are phase-aligned across channels.

Reset
REQ-024 While rst_n = 0, the following are all 0: prescaler, pwm_cnt, duty_sh, out, period_start.
REQ-025 Reset assertion mid-period clears state immediately (asynchronously); deassertion is synchronous to clock.
REQ-026 After deassertion, the first period runs with duty_sh = 0, so PWM channels are low until the first boundary load. The first boundary is at cycle 256*CLK_DIV after release.

Verification
REQ-027 Static: en_reg_out_7_0 = 0xA5, en_reg_out_15_8 = 0x0F, en_reg_pwm = 0 -> out = 0x0FA5 one cycle later, constant thereafter.
REQ-028 Duty 50%: en_out[0] = 1, en_pwm[0] = 1, duty = 0x80, CLK_DIV = 13 -> after the first boundary, out[0] high 1664 cycles and low 1664 cycles per 3328-cycle period.
REQ-029 Extremes: duty = 0x00 -> out[0] never high over 3 periods; duty = 0xFF -> out[0] never low over 3 periods after load.
REQ-030 Mid-period update: change duty 0x40 -> 0xC0 at pwm_cnt = 100 -> the current period keeps 832 high cycles; the next period has 2496 high cycles; period_start pulses exactly once per 3328 cycles.
REQ-031 Enable dominance and latency: en_pwm[3] = 1 with en_out[3] = 0 -> out[3] = 0. Then set en_out[3] = 1 -> out[3] follows pwm_sig from the next cycle.
REQ-032 Reset mid-operation: assert rst_n = 0 at pwm_cnt = 77 -> out = 0 and counters = 0 immediately. After release, the first load occurs at cycle 3328.
